// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: read-side front end for the synchronous FIFO.
// Prefetches words from a 1-cycle-latency FIFO read port into a two-entry
// buffer (head + skid) and presents them as a valid/ready stream that can
// sustain one beat per cycle.
// Optional build macro FIFO_STREAM_READER_BEAT_CNT_EN adds a 16-bit
// wrapping counter of accepted beats on port beat_cnt.
module fifo_stream_reader #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data
`ifdef FIFO_STREAM_READER_BEAT_CNT_EN
  ,
  output logic [15:0]      beat_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_state_t;

  buf_state_t       state;
  logic             valid_q;
  logic             inflight;
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] skid;

  logic             pop;
  logic [1:0]       occ;
  logic [2:0]       credit;

  assign m_valid = valid_q;
  assign m_data  = head;
  assign pop     = valid_q && m_ready;

  // Buffer occupancy as a number, for the read-credit calculation.
  always_comb begin
    occ = 2'd0;
    case (state)
      EMPTY:   occ = 2'd0;
      ONE:     occ = 2'd1;
      TWO:     occ = 2'd2;
      default: occ = 2'd0;
    endcase
  end

  // Issue a read only when the word will have a slot once it lands; a pop
  // this cycle frees a slot, so m_ready feeds fifo_rd_en combinationally.
  always_comb begin
    credit     = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    fifo_rd_en = en && !rst && !fifo_empty && (credit < 3'd2);
  end

  // Buffer FSM: capture arriving words, shift skid into head on pops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= EMPTY;
      valid_q  <= 1'b0;
      inflight <= 1'b0;
      head     <= '0;
      skid     <= '0;
    end else begin
      inflight <= fifo_rd_en;
      case (state)
        EMPTY: begin
          if (inflight) begin
            head    <= fifo_data;
            state   <= ONE;
            valid_q <= 1'b1;
          end
        end
        ONE: begin
          if (inflight && !pop) begin
            skid  <= fifo_data;
            state <= TWO;
          end else if (inflight && pop) begin
            head <= fifo_data;
          end else if (pop) begin
            state   <= EMPTY;
            valid_q <= 1'b0;
          end
        end
        TWO: begin
          // Arrival without a pop cannot happen here: the read credit
          // keeps occupancy plus in-flight words at two or fewer.
          if (pop) begin
            head <= skid;
            if (inflight) begin
              skid <= fifo_data;
            end else begin
              state <= ONE;
            end
          end
        end
        default: begin
          state   <= EMPTY;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef FIFO_STREAM_READER_BEAT_CNT_EN
  // Count accepted beats, wrapping at 16 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt <= '0;
    end else if (pop) begin
      beat_cnt <= beat_cnt + 16'd1;
    end
  end
`endif

endmodule
